// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type, default timeout and the request legality check.
package load_store_unit_pkg;

  localparam int LSU_DATA_WIDTH      = 32;
  localparam int LSU_ADDR_WIDTH      = 32;
  localparam int LSU_REG_ADDR_WIDTH  = 5;
  localparam int LSU_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_ACCESS = 2'b01,
    LSU_RESP   = 2'b10
  } lsu_state_e;

  // A request faults when its funct3 has no meaning for the access type,
  // or when a halfword/word is not naturally aligned. funct3[1:0] encodes
  // the size for every legal load and store.
  function automatic logic lsu_fault(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic illegal;
    logic mis_half;
    logic mis_word;
    if (is_store) begin
      illegal = (funct3 > FUNCT3_SW);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    mis_half = (funct3[1:0] == 2'b01) && addr_lo[0];
    mis_word = (funct3[1:0] == 2'b10) && (addr_lo != 2'b00);
    return illegal | mis_half | mis_word;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   is_store_i, funct3_i, addr_lo_i : access type, size/sign and byte offset
//   wdata_i                         : raw store data (rs2)
//   rdata_i                         : word returned by memory
//   we_o, wdata_o                   : byte strobes and lane-replicated store data
//   load_o                          : extracted and extended load value
//   fault_o                         : illegal funct3 or misaligned address
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o,
  output logic        fault_o
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign fault_o = lsu_fault(is_store_i, funct3_i, addr_lo_i);

  // Stores replicate the datum across every lane it may land in so the
  // strobes alone select the destination bytes.
  always_comb begin
    we_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    if (is_store_i) begin
      case (funct3_i)
        FUNCT3_SB: begin
          we_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        FUNCT3_SH: begin
          we_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        FUNCT3_SW: begin
          we_o    = 4'b1111;
          wdata_o = wdata_i;
        end
        default: begin
          we_o    = 4'b0000;
          wdata_o = 32'h0000_0000;
        end
      endcase
    end
  end

  assign load_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign load_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_o = 32'h0000_0000;
    case (funct3_i)
      FUNCT3_LB:  load_o = {{24{load_byte[7]}}, load_byte};
      FUNCT3_LH:  load_o = {{16{load_half[15]}}, load_half};
      FUNCT3_LW:  load_o = rdata_i;
      FUNCT3_LBU: load_o = {24'h000000, load_byte};
      FUNCT3_LHU: load_o = {16'h0000, load_half};
      default:    load_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one load/store, performs a word-aligned memory
// access with byte strobes and returns a one-cycle write-back/done response.
// Ports:
//   clk, rst                    : clock and asynchronous active-high reset
//   req_*                       : request handshake and fields from the ALU stage
//   mem_*                       : data memory interface (mem_en held until mem_ack)
//   wb_en_o, wb_addr_o, wb_data_o : register file write port
//   done_o, misaligned_o, bus_err_o : completion pulse and outcome flags
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH     = LSU_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH = LSU_REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_is_store_i,
  input  logic [2:0]                req_funct3_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,
  output logic                      mem_en_o,
  output logic [3:0]                mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic                      mem_ack_i,
  output logic                      wb_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      done_o,
  output logic                      misaligned_o,
  output logic                      bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e                state_q;
  logic                      ready_q;
  logic                      is_store_q;
  logic [2:0]                funct3_q;
  logic [1:0]                addr_lo_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      mem_en_q;
  logic [3:0]                mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0]     mem_wdata_q;
  logic                      wb_en_q;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic                      done_q;
  logic                      misaligned_q;
  logic                      bus_err_q;

  logic                      align_is_store_d;
  logic [2:0]                align_funct3_d;
  logic [1:0]                align_addr_lo_d;
  logic [3:0]                align_we;
  logic [31:0]               align_wdata;
  logic [31:0]               align_load;
  logic                      align_fault;

  // One lane unit serves both phases: in IDLE it checks and formats the
  // incoming request, afterwards it extracts load data for the latched one.
  assign align_is_store_d = (state_q == LSU_IDLE) ? req_is_store_i  : is_store_q;
  assign align_funct3_d   = (state_q == LSU_IDLE) ? req_funct3_i    : funct3_q;
  assign align_addr_lo_d  = (state_q == LSU_IDLE) ? req_addr_i[1:0] : addr_lo_q;

  load_store_unit_align u_align (
    .is_store_i (align_is_store_d),
    .funct3_i   (align_funct3_d),
    .addr_lo_i  (align_addr_lo_d),
    .wdata_i    (req_wdata_i),
    .rdata_i    (mem_rdata_i),
    .we_o       (align_we),
    .wdata_o    (align_wdata),
    .load_o     (align_load),
    .fault_o    (align_fault)
  );

  // ready_q resets low and rises one cycle later so that req_ready is 0
  // while reset is held. RESP outputs default to 0 and are set only on the
  // transition into RESP, which makes them single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      ready_q      <= 1'b0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      rd_q         <= '0;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (ready_q && req_valid_i) begin
            ready_q    <= 1'b0;
            is_store_q <= req_is_store_i;
            funct3_q   <= req_funct3_i;
            addr_lo_q  <= req_addr_i[1:0];
            rd_q       <= req_rd_i;
            cnt_q      <= '0;
            if (align_fault) begin
              state_q      <= LSU_RESP;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
              wb_addr_q    <= req_rd_i;
            end else begin
              state_q     <= LSU_ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= align_we;
              mem_addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= align_wdata;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        LSU_ACCESS: begin
          // An ack on the final allowed cycle still completes the access.
          if (mem_ack_i || (cnt_q == CNT_LAST)) begin
            state_q     <= LSU_RESP;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b1;
            wb_addr_q   <= rd_q;
            if (!mem_ack_i) begin
              bus_err_q <= 1'b1;
            end else if (!is_store_q && (rd_q != '0)) begin
              wb_en_q   <= 1'b1;
              wb_data_q <= align_load;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LSU_RESP: begin
          state_q <= LSU_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= LSU_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wb_en_o      = wb_en_q;
  assign wb_addr_o    = wb_addr_q;
  assign wb_data_o    = wb_data_q;
  assign done_o       = done_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;

endmodule
